// File: rtl/bp_nonsynth_dma_beat_mem.sv
// bp_nonsynth_dma_beat_mem
// -------------------------------------------------------------------------
// Single-channel DRAM model for the L2 DMA side of the processor wrapper.
// It accepts one bsg_cache_dma packet at a time. A write packet is followed
// by dma_burst_len_p write beats, and each beat is merged into storage under
// the packet mask. A read packet returns dma_burst_len_p beats. The first
// read beat appears read_latency_p cycles after the packet is accepted.
//
// Ports
//   clk_i                 clock
//   reset_i               asynchronous active-high reset (storage is kept)
//   dma_pkt_i             {write_not_read, mask, addr}
//   dma_pkt_v_i           packet valid
//   dma_pkt_yumi_o        packet consumed this cycle (IDLE only)
//   dma_data_o            read beat, held stable while stalled
//   dma_data_v_o          read beat valid
//   dma_data_ready_and_i  consumer ready for read beat
//   dma_data_i            write beat
//   dma_data_v_i          write beat valid
//   dma_data_yumi_o       write beat consumed
//   rd_count_o            completed read bursts (wraps at 2^32)
//   wr_count_o            completed write bursts (wraps at 2^32)
// -------------------------------------------------------------------------
module bp_nonsynth_dma_beat_mem #(
    parameter int dma_addr_width_p = 28,
    parameter int dma_data_width_p = 64,
    parameter int dma_burst_len_p  = 8,
    parameter int dma_mask_width_p = 8,
    parameter int mem_els_p        = 1024,
    parameter int read_latency_p   = 4
) (
    input  logic                                            clk_i,
    input  logic                                            reset_i,
    input  logic [dma_mask_width_p+dma_addr_width_p:0]      dma_pkt_i,
    input  logic                                            dma_pkt_v_i,
    output logic                                            dma_pkt_yumi_o,
    output logic [dma_data_width_p-1:0]                     dma_data_o,
    output logic                                            dma_data_v_o,
    input  logic                                            dma_data_ready_and_i,
    input  logic [dma_data_width_p-1:0]                     dma_data_i,
    input  logic                                            dma_data_v_i,
    output logic                                            dma_data_yumi_o,
    output logic [31:0]                                     rd_count_o,
    output logic [31:0]                                     wr_count_o
);

    localparam int WPB         = dma_mask_width_p / dma_burst_len_p;
    localparam int WORD_W      = dma_data_width_p / WPB;
    localparam int BLOCK_BYTES = dma_data_width_p * dma_burst_len_p / 8;
    localparam int OFFSET_W    = $clog2(BLOCK_BYTES);
    localparam int MEM_AW      = $clog2(mem_els_p);
    localparam int BEAT_W      = (dma_burst_len_p > 1) ? $clog2(dma_burst_len_p) : 1;
    localparam int MASK_IW     = (dma_mask_width_p > 1) ? $clog2(dma_mask_width_p) : 1;
    localparam int LAT_W       = $clog2(read_latency_p + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_SEND = 2'd2,
        WR_RECV = 2'd3
    } state_e;

    state_e state_reg, state_next;

    // Packet fields
    logic                        pkt_wnr;
    logic [dma_mask_width_p-1:0] pkt_mask;
    logic [dma_addr_width_p-1:0] pkt_addr;

    assign pkt_wnr  = dma_pkt_i[dma_mask_width_p+dma_addr_width_p];
    assign pkt_mask = dma_pkt_i[dma_addr_width_p +: dma_mask_width_p];
    assign pkt_addr = dma_pkt_i[dma_addr_width_p-1:0];

    // Latched burst context. The direction is carried by the FSM state.
    logic [dma_addr_width_p-1:0] addr_reg;
    logic [dma_mask_width_p-1:0] mask_reg;
    logic [BEAT_W-1:0]           beat_reg;
    logic [LAT_W-1:0]            lat_reg;
    logic [dma_data_width_p-1:0] data_reg;
    logic [31:0]                 rd_count_reg;
    logic [31:0]                 wr_count_reg;

    // Storage is zero at time 0 and is not touched by reset.
    logic [dma_data_width_p-1:0] mem [mem_els_p] = '{default: '0};

    logic pkt_fire;
    logic rd_fire;
    logic wr_fire;
    logic last_beat;
    logic rd_load;

    assign pkt_fire  = dma_pkt_yumi_o;
    assign rd_fire   = dma_data_v_o & dma_data_ready_and_i;
    assign wr_fire   = dma_data_yumi_o;
    assign last_beat = (beat_reg == BEAT_W'(dma_burst_len_p - 1));

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pkt_fire) begin
                    if (pkt_wnr) begin
                        state_next = WR_RECV;
                    end else if (read_latency_p == 1) begin
                        state_next = RD_SEND;
                    end else begin
                        state_next = RD_WAIT;
                    end
                end
            end
            // The counter is loaded with read_latency_p-1. Leaving when it is
            // about to reach zero puts the first beat exactly read_latency_p
            // cycles after the accept cycle.
            RD_WAIT: begin
                if (lat_reg == LAT_W'(1)) begin
                    state_next = RD_SEND;
                end
            end
            RD_SEND: begin
                if (rd_fire && last_beat) begin
                    state_next = IDLE;
                end
            end
            WR_RECV: begin
                if (wr_fire && last_beat) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs. The handshakes are gated with reset so that they drop
    // in the same cycle that reset is asserted.
    // ---------------------------------------------------------------------
    always_comb begin
        dma_pkt_yumi_o  = 1'b0;
        dma_data_v_o    = 1'b0;
        dma_data_yumi_o = 1'b0;
        case (state_reg)
            IDLE:    dma_pkt_yumi_o  = dma_pkt_v_i & ~reset_i;
            RD_SEND: dma_data_v_o    = ~reset_i;
            WR_RECV: dma_data_yumi_o = dma_data_v_i & ~reset_i;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Burst context and counters
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_reg     <= '0;
            mask_reg     <= '0;
            beat_reg     <= '0;
            lat_reg      <= '0;
            rd_count_reg <= '0;
            wr_count_reg <= '0;
        end else begin
            if (pkt_fire) begin
                addr_reg <= pkt_addr;
                mask_reg <= pkt_mask;
                beat_reg <= '0;
                lat_reg  <= LAT_W'(read_latency_p - 1);
            end
            if (state_reg == RD_WAIT) begin
                lat_reg <= lat_reg - LAT_W'(1);
            end
            if (rd_fire || wr_fire) begin
                beat_reg <= beat_reg + BEAT_W'(1);
            end
            if (rd_fire && last_beat) begin
                rd_count_reg <= rd_count_reg + 32'd1;
            end
            if (wr_fire && last_beat) begin
                wr_count_reg <= wr_count_reg + 32'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Storage addressing. Mod mem_els_p is plain truncation because the
    // depth is a power of two, so oversized addresses wrap silently. In IDLE
    // the incoming packet address is used, which lets a latency-1 read
    // fetch its first beat during the accept cycle.
    // ---------------------------------------------------------------------
    logic [dma_addr_width_p-1:0] base_addr;
    logic [MEM_AW-1:0]           block_base;
    logic [BEAT_W-1:0]           rd_beat;
    logic [MEM_AW-1:0]           rd_idx;
    logic [MEM_AW-1:0]           wr_idx;

    assign base_addr  = (state_reg == IDLE) ? pkt_addr : addr_reg;
    assign block_base = MEM_AW'(base_addr >> OFFSET_W) * MEM_AW'(dma_burst_len_p);
    // The register is loaded one cycle ahead, so the read port looks at
    // the beat that comes after the one being presented.
    assign rd_beat    = (state_reg == RD_SEND) ? (beat_reg + BEAT_W'(1)) : '0;
    assign rd_idx     = block_base + MEM_AW'(rd_beat);
    assign wr_idx     = block_base + MEM_AW'(beat_reg);

    // Load the output register when entering RD_SEND and after every beat
    // except the last. Otherwise it holds, which keeps a stalled beat stable.
    assign rd_load = (pkt_fire && !pkt_wnr && (read_latency_p == 1))
                   || ((state_reg == RD_WAIT) && (lat_reg == LAT_W'(1)))
                   || (rd_fire && !last_beat);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_reg <= '0;
        end else if (rd_load) begin
            data_reg <= mem[rd_idx];
        end
    end

    // Per-word write enables. Beat b owns mask bits b*WPB .. b*WPB+WPB-1.
    logic [MASK_IW-1:0] mask_base;
    logic [WPB-1:0]     word_we;

    assign mask_base = MASK_IW'(beat_reg) * MASK_IW'(WPB);

    generate
        for (genvar gi = 0; gi < WPB; gi++) begin : g_word_we
            assign word_we[gi] = wr_fire & mask_reg[mask_base + MASK_IW'(gi)];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        for (int j = 0; j < WPB; j++) begin
            if (word_we[j]) begin
                mem[wr_idx][j*WORD_W +: WORD_W] <= dma_data_i[j*WORD_W +: WORD_W];
            end
        end
    end

    assign dma_data_o = data_reg;
    assign rd_count_o = rd_count_reg;
    assign wr_count_o = wr_count_reg;

endmodule
